// File: rtl/alpha_operand_sequencer_pkg.sv
// Shared definitions for the alpha operand sequencer of the FLAC LPC
// Levinson-Durbin datapath: float constants, default order and the
// sequencer state encoding.
package alpha_operand_sequencer_pkg;

    localparam int ORDER_DEFAULT = 12;

    // IEEE-754 single-precision bit patterns (opaque to this block)
    localparam logic [31:0] FP_ONE  = 32'h3f80_0000;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } seq_state_t;

endpackage

// File: rtl/flac_coef_regfile.sv
// One-write / two-read register file holding coefficient words.
// Reads are combinational, so a read in the same cycle as a write to the
// same address sees the old contents; the write lands on the clock edge.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   en                clock enable for the write port
//   we/waddr/wdata    write port
//   raddr_a/rdata_a   read port A
//   raddr_b/rdata_b   read port B
// Reset image: word 0 = RESET_WORD0, all others zero.
module flac_coef_regfile #(
    parameter int                    DEPTH       = 13,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_WORD0 = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    output logic [DATA_WIDTH-1:0] rdata_b
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= (i == 0) ? RESET_WORD0 : '0;
            end
        end else if (en && we && (int'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    // Out-of-range addresses read as zero rather than X
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (int'(raddr_a) < DEPTH) rdata_a = mem[raddr_a];
        if (int'(raddr_b) < DEPTH) rdata_b = mem[raddr_b];
    end

endmodule

// File: rtl/alpha_operand_sequencer.sv
// Operand sequencer for the Levinson-Durbin alpha accumulation:
//   alpha_m = sum_{j=0..m} model[j] * acf[m+1-j]
// Holds the ACF vector and LPC model, and for each started iteration m
// streams floor(m/2)+1 beats of two operand pairs each:
//   beat t: oModel1 = model[2t],   oACF2 = acf[m+1-2t]
//           oModel2 = model[2t+1], oACF1 = acf[m-2t]   (zero if 2t+1 > m)
// Ports:
//   iClock, iReset        clock, asynchronous active-high reset
//   iEnable               clock enable, low freezes everything
//   iACFValid, iACF       ACF load stream (index order 0..ORDER)
//   iModelWrite/Addr/Data model coefficient write port
//   iStart, iM            iteration start request and index
//   oACFReady             all ORDER+1 ACF words held
//   oValid, oM            beat valid and iteration index of the beat
//   oACF1/2, oModel1/2    operand pair outputs
//   oBusy, oDone, oErr    streaming, end-of-stream pulse, rejected start
module alpha_operand_sequencer
    import alpha_operand_sequencer_pkg::*;
#(
    parameter int ORDER      = ORDER_DEFAULT,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iEnable,
    input  logic                  iACFValid,
    input  logic [DATA_WIDTH-1:0] iACF,
    input  logic                  iModelWrite,
    input  logic [3:0]            iModelAddr,
    input  logic [DATA_WIDTH-1:0] iModelData,
    input  logic                  iStart,
    input  logic [3:0]            iM,
    output logic                  oACFReady,
    output logic                  oValid,
    output logic [3:0]            oM,
    output logic [DATA_WIDTH-1:0] oACF1,
    output logic [DATA_WIDTH-1:0] oACF2,
    output logic [DATA_WIDTH-1:0] oModel1,
    output logic [DATA_WIDTH-1:0] oModel2,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oErr
);

    localparam int              AW        = 4;
    localparam int              ACF_DEPTH = ORDER + 1;
    localparam logic [AW:0]     ACF_FULL  = ACF_DEPTH[AW:0];
    localparam logic [AW:0]     CNT_ONE   = 1;
    localparam logic [AW-1:0]   IDX_ONE   = 1;
    localparam logic [DATA_WIDTH-1:0] WORD_ZERO = DATA_WIDTH'(FP_ZERO);
    localparam logic [DATA_WIDTH-1:0] WORD_ONE  = DATA_WIDTH'(FP_ONE);

    // ---------------- ACF load counter ----------------
    logic [AW:0] acf_count;
    logic        acf_ready;
    logic        acf_load;
    logic [AW:0] acf_count_inc;

    assign acf_load      = iACFValid && (acf_count != ACF_FULL);
    assign acf_count_inc = acf_count + CNT_ONE;

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            acf_count <= '0;
            acf_ready <= 1'b0;
        end else if (iEnable && acf_load) begin
            acf_count <= acf_count_inc;
            acf_ready <= (acf_count_inc == ACF_FULL);
        end
    end

    // ---------------- Sequencer state ----------------
    seq_state_t    state, state_next;
    logic [3:0]    m_q, m_next;
    logic [AW-1:0] t_q, t_next;

    // Index arithmetic for beat t; all indices stay below ORDER+1
    logic [AW-1:0] twice_t;
    logic [AW-1:0] acf_idx1, acf_idx2, model_idx1, model_idx2;
    logic          has_second, is_last;

    assign twice_t    = {t_q[AW-2:0], 1'b0};
    assign model_idx1 = twice_t;
    assign model_idx2 = twice_t + IDX_ONE;
    assign acf_idx2   = m_q + IDX_ONE - twice_t;
    assign acf_idx1   = m_q - twice_t;
    assign has_second = (twice_t < m_q);      // 2t+1 <= m
    assign is_last    = (t_q == (m_q >> 1));  // t == floor(m/2)

    logic [DATA_WIDTH-1:0] acf_rd1, acf_rd2, model_rd1, model_rd2;

    flac_coef_regfile #(
        .DEPTH       (ACF_DEPTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (AW),
        .RESET_WORD0 (WORD_ZERO)
    ) u_acf (
        .clk     (iClock),
        .rst     (iReset),
        .en      (iEnable),
        .we      (acf_load),
        .waddr   (acf_count[AW-1:0]),
        .wdata   (iACF),
        .raddr_a (acf_idx1),
        .rdata_a (acf_rd1),
        .raddr_b (acf_idx2),
        .rdata_b (acf_rd2)
    );

    flac_coef_regfile #(
        .DEPTH       (ORDER),
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (AW),
        .RESET_WORD0 (WORD_ONE)
    ) u_model (
        .clk     (iClock),
        .rst     (iReset),
        .en      (iEnable),
        .we      (iModelWrite),
        .waddr   (iModelAddr),
        .wdata   (iModelData),
        .raddr_a (model_idx1),
        .rdata_a (model_rd1),
        .raddr_b (model_idx2),
        .rdata_b (model_rd2)
    );

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state <= ST_IDLE;
            m_q   <= '0;
            t_q   <= '0;
        end else if (iEnable) begin
            state <= state_next;
            m_q   <= m_next;
            t_q   <= t_next;
        end
    end

    logic                  valid_next, done_next, err_next;
    logic [3:0]            m_out_next;
    logic [DATA_WIDTH-1:0] acf1_next, acf2_next, model1_next, model2_next;

    always_comb begin
        state_next  = state;
        m_next      = m_q;
        t_next      = t_q;
        valid_next  = 1'b0;
        done_next   = 1'b0;
        err_next    = 1'b0;
        m_out_next  = '0;
        acf1_next   = WORD_ZERO;
        acf2_next   = WORD_ZERO;
        model1_next = WORD_ZERO;
        model2_next = WORD_ZERO;
        case (state)
            ST_IDLE: begin
                if (iStart) begin
                    if (acf_ready && (int'(iM) < ORDER)) begin
                        state_next = ST_STREAM;
                        m_next     = iM;
                        t_next     = '0;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                valid_next  = 1'b1;
                m_out_next  = m_q;
                model1_next = model_rd1;
                acf2_next   = acf_rd2;
                if (has_second) begin
                    model2_next = model_rd2;
                    acf1_next   = acf_rd1;
                end
                if (is_last) state_next = ST_DONE;
                else         t_next     = t_q + IDX_ONE;
            end
            ST_DONE: begin
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- Output register stage ----------------
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            oValid  <= 1'b0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            oErr    <= 1'b0;
            oM      <= '0;
            oACF1   <= '0;
            oACF2   <= '0;
            oModel1 <= '0;
            oModel2 <= '0;
        end else if (iEnable) begin
            oValid  <= valid_next;
            oBusy   <= valid_next;
            oDone   <= done_next;
            oErr    <= err_next;
            oM      <= m_out_next;
            oACF1   <= acf1_next;
            oACF2   <= acf2_next;
            oModel1 <= model1_next;
            oModel2 <= model2_next;
        end
    end

    assign oACFReady = acf_ready;

endmodule
